// File: rtl/board_scan.sv
// LED matrix row scanner: latches a 32-bit board at frame boundaries and refreshes rows by
// shifting column bits serially, strobing a latch, then enabling the row for a fixed dwell.
module board_scan #(
  parameter int unsigned ROWS    = 8,
  parameter int unsigned COLS    = 4,
  parameter int unsigned CLK_DIV = 2,
  parameter int unsigned DWELL   = 16
) (
  input  logic                 clka,
  input  logic                 restart_n,
  input  logic [ROWS*COLS-1:0] board_in,
  input  logic                 board_valid,
  output logic                 board_ack,
  output logic                 ser_data,
  output logic                 ser_clk,
  output logic                 ser_latch,
  output logic [ROWS-1:0]      row_sel,
  output logic                 row_en,
  output logic                 frame_done
);

  localparam int unsigned SubW = $clog2(2 * CLK_DIV);
  localparam int unsigned BitW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int unsigned RowW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int unsigned DwW  = (DWELL > 1) ? $clog2(DWELL) : 1;

  localparam logic [SubW-1:0] SubLast = SubW'(2 * CLK_DIV - 1);
  localparam logic [SubW-1:0] SubHigh = SubW'(CLK_DIV);
  localparam logic [BitW-1:0] BitLast = BitW'(COLS - 1);
  localparam logic [RowW-1:0] RowLast = RowW'(ROWS - 1);
  localparam logic [DwW-1:0]  DwLast  = DwW'(DWELL - 1);

  typedef enum logic [1:0] {StFrame, StShift, StLatch, StDwell} state_e;

  state_e                 r_state, w_state_d;
  logic [ROWS*COLS-1:0]   r_frame, w_frame_d;
  logic [RowW-1:0]        r_row, w_row_d;
  logic [SubW-1:0]        r_sub, w_sub_d;
  logic [BitW-1:0]        r_bit, w_bit_d;
  logic [DwW-1:0]         r_dwell, w_dwell_d;
  logic [ROWS-1:0]        r_row_sel, w_row_sel_d;

  logic [ROWS*COLS-1:0]   w_frame_sh;
  logic [COLS-1:0]        w_row_bits;
  logic [COLS-1:0]        w_col_sh;
  logic [ROWS-1:0]        w_onehot;

  // Current row's bits, then MSB column first by shifting the bit index up to the top.
  assign w_frame_sh = r_frame >> (32'(r_row) * COLS);
  assign w_row_bits = w_frame_sh[COLS-1:0];
  assign w_col_sh   = w_row_bits << r_bit;
  assign w_onehot   = ROWS'(1) << r_row;

  always_ff @(posedge clka or negedge restart_n) begin
    if (!restart_n) begin
      r_state   <= StFrame;
      r_frame   <= '0;
      r_row     <= '0;
      r_sub     <= '0;
      r_bit     <= '0;
      r_dwell   <= '0;
      r_row_sel <= '0;
    end else begin
      r_state   <= w_state_d;
      r_frame   <= w_frame_d;
      r_row     <= w_row_d;
      r_sub     <= w_sub_d;
      r_bit     <= w_bit_d;
      r_dwell   <= w_dwell_d;
      r_row_sel <= w_row_sel_d;
    end
  end

  always_comb begin
    w_state_d   = r_state;
    w_frame_d   = r_frame;
    w_row_d     = r_row;
    w_sub_d     = r_sub;
    w_bit_d     = r_bit;
    w_dwell_d   = r_dwell;
    w_row_sel_d = r_row_sel;
    board_ack   = 1'b0;
    ser_data    = 1'b0;
    ser_clk     = 1'b0;
    ser_latch   = 1'b0;
    row_sel     = r_row_sel;
    row_en      = 1'b0;
    frame_done  = 1'b0;

    unique case (r_state)
      StFrame: begin
        // Gated by reset so the ack stays low while the block is held in reset.
        if (board_valid && restart_n) begin
          board_ack = 1'b1;
          w_frame_d = board_in;
        end
        w_row_d   = '0;
        w_sub_d   = '0;
        w_bit_d   = '0;
        w_state_d = StShift;
      end
      StShift: begin
        ser_data = w_col_sh[COLS-1];
        ser_clk  = (r_sub >= SubHigh);
        if (r_sub == SubLast) begin
          w_sub_d = '0;
          if (r_bit == BitLast) begin
            w_bit_d   = '0;
            w_state_d = StLatch;
          end else begin
            w_bit_d = r_bit + 1'b1;
          end
        end else begin
          w_sub_d = r_sub + 1'b1;
        end
      end
      StLatch: begin
        ser_latch   = 1'b1;
        row_sel     = w_onehot;
        w_row_sel_d = w_onehot;
        w_dwell_d   = '0;
        w_state_d   = StDwell;
      end
      StDwell: begin
        row_en = 1'b1;
        if (r_dwell == DwLast) begin
          if (r_row == RowLast) begin
            frame_done = 1'b1;
            w_row_d    = '0;
            w_state_d  = StFrame;
          end else begin
            w_row_d   = r_row + 1'b1;
            w_state_d = StShift;
          end
        end else begin
          w_dwell_d = r_dwell + 1'b1;
        end
      end
      default: w_state_d = StFrame;
    endcase
  end

endmodule
